// File: rtl/tdm_pkg.sv
// Shared constants, state type and mask helper for the 8:1 TDM multiplexer.
package tdm_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tdm_state_t;

  // Index of the lowest set bit; returns 0 for an empty mask.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
    lowest_set = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = SEL_W'(i);
    end
  endfunction

endpackage

// File: rtl/tdm_mux_8to1_if.sv
// Serial link side of the TDM multiplexer: slot data, channel tag, framing and flow control.
interface tdm_mux_8to1_if #(
  parameter int WIDTH = 1
) ();
  import tdm_pkg::*;

  logic [WIDTH-1:0] out;
  logic [SEL_W-1:0] sel;
  logic             valid;
  logic             frame_sync;
  logic             frame_done;
  logic             out_ready;

  modport master (
    output out, sel, valid, frame_sync, frame_done,
    input  out_ready
  );

  modport slave (
    input  out, sel, valid, frame_sync, frame_done,
    output out_ready
  );
endinterface

// File: rtl/tdm_next_ch.sv
// Finds the next enabled channel strictly above the current slot within a frame.
module tdm_next_ch
  import tdm_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  sel,
  output logic [SEL_W-1:0]  next_sel,
  output logic              has_next
);

  // Scan downwards so the last hit is the closest set bit above sel.
  always_comb begin
    next_sel = sel;
    has_next = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(sel))) begin
        next_sel = SEL_W'(i);
        has_next = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdm_mux_8to1.sv
// 8:1 time-division multiplexer: snapshots 8 channels per frame and sends the
// enabled ones in ascending order, each slot held for HOLD accepted beats.
module tdm_mux_8to1
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int HOLD  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       ch_mask,
  input  logic [NUM_CH*WIDTH-1:0] in,
  tdm_mux_8to1_if.master          link
);

  localparam int              HCW       = $clog2(HOLD + 1);
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD - 1);

  tdm_state_t              state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [NUM_CH-1:0]       mask_q, mask_d;
  logic [NUM_CH*WIDTH-1:0] shadow_q, shadow_d;
  logic [HCW-1:0]          hold_cnt_q, hold_cnt_d;
  logic [WIDTH-1:0]        out_q, out_d;
  logic                    valid_q, valid_d;
  logic                    frame_sync_q, frame_sync_d;
  logic                    frame_done_q, frame_done_d;

  logic [SEL_W-1:0]        next_sel;
  logic                    has_next;
  logic                    capture_ok;
  logic                    accept;
  logic                    start_frame;
  logic [SEL_W-1:0]        cap_sel;

  tdm_next_ch u_next_ch (
    .mask     (mask_q),
    .sel      (sel_q),
    .next_sel (next_sel),
    .has_next (has_next)
  );

  assign capture_ok = en && (ch_mask != '0);
  assign cap_sel    = lowest_set(ch_mask);
  assign accept     = valid_q && link.out_ready;

  // Next-state and output logic: frame capture, slot advance, frame end.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    mask_d       = mask_q;
    shadow_d     = shadow_q;
    hold_cnt_d   = hold_cnt_q;
    out_d        = out_q;
    valid_d      = valid_q;
    frame_sync_d = frame_sync_q;
    frame_done_d = 1'b0;
    start_frame  = 1'b0;

    case (state_q)
      IDLE: begin
        valid_d      = 1'b0;
        frame_sync_d = 1'b0;
        start_frame  = capture_ok;
      end
      SEND: begin
        if (accept) begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = '0;
            if (has_next) begin
              sel_d        = next_sel;
              out_d        = shadow_q[int'(next_sel)*WIDTH +: WIDTH];
              frame_sync_d = 1'b0;
            end else begin
              // Last beat of the frame: either roll straight into a new frame or go idle.
              frame_done_d = 1'b1;
              if (capture_ok) begin
                start_frame = 1'b1;
              end else begin
                state_d      = IDLE;
                valid_d      = 1'b0;
                frame_sync_d = 1'b0;
                out_d        = '0;
              end
            end
          end else begin
            hold_cnt_d = hold_cnt_q + HCW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_frame) begin
      state_d      = SEND;
      shadow_d     = in;
      mask_d       = ch_mask;
      sel_d        = cap_sel;
      out_d        = in[int'(cap_sel)*WIDTH +: WIDTH];
      valid_d      = 1'b1;
      frame_sync_d = 1'b1;
      hold_cnt_d   = '0;
    end
  end

  // State, snapshot and output registers; async reset returns everything to idle zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      mask_q       <= '0;
      shadow_q     <= '0;
      hold_cnt_q   <= '0;
      out_q        <= '0;
      valid_q      <= 1'b0;
      frame_sync_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      mask_q       <= mask_d;
      shadow_q     <= shadow_d;
      hold_cnt_q   <= hold_cnt_d;
      out_q        <= out_d;
      valid_q      <= valid_d;
      frame_sync_q <= frame_sync_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign link.out        = out_q;
  assign link.sel        = sel_q;
  assign link.valid      = valid_q;
  assign link.frame_sync = frame_sync_q;
  assign link.frame_done = frame_done_q;

endmodule
